multicycle_controller: RTL and testbench

Multi-cycle sequencer for the RV32I core datapath. It replaces single-cycle control when instruction and data memories carry variable latency. It steps each instruction through BOOT/FETCH/DECODE/EXEC/MEM/WB, holds memory requests until the memory acknowledges, and pulses the architectural write enables exactly once per instruction. It also keeps a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 44 ++++
 rtl/multicycle_controller.sv | 122 ++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcode
// encodings (inst[6:2]), sequencer state encoding and store byte masks.
package rv_ctrl_pkg;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // True for any opcode the sequencer knows how to step through.
    function automatic logic is_legal(input logic [4:0] op);
        return (op == OPC_LUI)    || (op == OPC_AUIPC) || (op == OPC_JAL)   ||
               (op == OPC_JALR)   || (op == OPC_BRANCH)|| (op == OPC_LOAD)  ||
               (op == OPC_STORE)  || (op == OPC_OPIMM) || (op == OPC_OP);
    endfunction

    // Store byte-enable mask from func3 (SB / SH / SW).
    function automatic logic [3:0] store_mask(input logic [2:0] f3);
        case (f3)
            3'b000:  return MASK_BYTE;
            3'b001:  return MASK_HALF;
            default: return MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: steps each instruction through
// BOOT/FETCH/DECODE/EXEC/MEM/WB, holds memory requests until acknowledged,
// pulses architectural write enables once per instruction and counts
// retired instructions. All outputs except instret are state decodes, so
// reset forces them low immediately.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         opcode,
    input  logic [2:0]         func3,
    input  logic               alu_out,
    input  logic               im_ready,
    input  logic               dm_ready,
    output logic               im_req,
    output logic               ir_w_en,
    output logic               dm_req,
    output logic [3:0]         dm_w_en,
    output logic               wb_en,
    output logic               wb_sel,
    output logic               pc_w_en,
    output logic               next_pc_sel,
    output logic               alu_op1_sel,
    output logic               alu_op2_sel,
    output logic               jb_op1_sel,
    output logic               illegal,
    output logic [COUNT_W-1:0] instret
);

    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] instret_reg;
    logic               in_datapath;
    logic               op_is_jump;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_BOOT;
        else        state_reg <= state_next;
    end

    // Retired-instruction counter: one tick per PC update, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       instret_reg <= '0;
        else if (pc_w_en) instret_reg <= instret_reg + COUNT_W'(1);
    end

    assign instret     = instret_reg;
    assign in_datapath = (state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                         (state_reg == ST_MEM)    || (state_reg == ST_WB);
    assign op_is_jump  = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    // Next-state logic and per-state control decode.
    always_comb begin
        state_next  = state_reg;
        im_req      = 1'b0;
        ir_w_en     = 1'b0;
        dm_req      = 1'b0;
        dm_w_en     = 4'b0000;
        wb_en       = 1'b0;
        pc_w_en     = 1'b0;
        next_pc_sel = 1'b0;
        illegal     = 1'b0;
        // Operand/writeback selects only matter once the IR holds the
        // instruction, so they stay low while booting or fetching.
        alu_op1_sel = in_datapath && ((opcode == OPC_AUIPC) || op_is_jump);
        alu_op2_sel = in_datapath && !((opcode == OPC_OP) || (opcode == OPC_BRANCH));
        jb_op1_sel  = in_datapath && (opcode != OPC_JALR);
        wb_sel      = in_datapath && (opcode != OPC_LOAD);
        case (state_reg)
            ST_BOOT: state_next = ST_FETCH;
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    ir_w_en    = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
                    state_next = ST_MEM;
                end else if (opcode == OPC_BRANCH) begin
                    pc_w_en     = 1'b1;
                    next_pc_sel = ~alu_out;
                    state_next  = ST_FETCH;
                end else if (!is_legal(opcode)) begin
                    // Skip the bad instruction: flag it and step PC+4.
                    pc_w_en     = 1'b1;
                    next_pc_sel = 1'b1;
                    illegal     = 1'b1;
                    state_next  = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req = 1'b1;
                if (opcode == OPC_STORE) dm_w_en = store_mask(func3);
                if (dm_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_w_en     = 1'b1;
                        next_pc_sel = 1'b1;
                        state_next  = ST_FETCH;
                    end else begin
                        state_next  = ST_WB;
                    end
                end
            end
            ST_WB: begin
                wb_en       = 1'b1;
                pc_w_en     = 1'b1;
                next_pc_sel = ~op_is_jump;
                state_next  = ST_FETCH;
            end
            default: state_next = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller. A per-instruction reference
// builds the expected cycle-by-cycle output trace from the instruction's
// class and memory wait counts; two DUTs (32-bit and 4-bit counter) share
// the stimulus so counter wrap is covered.
module tb_multicycle_controller;

    localparam logic [4:0] LUI = 5'b01101, AUIPC = 5'b00101, JAL = 5'b11011,
                           JALR = 5'b11001, BRANCH = 5'b11000, LOAD = 5'b00000,
                           STORE = 5'b01000, OPIMM = 5'b00100, OP = 5'b01100;

    logic        clk, rst_n;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        alu_out, im_ready, dm_ready;

    logic        im_req, ir_w_en, dm_req, wb_en, wb_sel, pc_w_en, next_pc_sel;
    logic        alu_op1_sel, alu_op2_sel, jb_op1_sel, illegal;
    logic [3:0]  dm_w_en;
    logic [31:0] instret;

    logic        im_req4, ir_w_en4, dm_req4, wb_en4, wb_sel4, pc_w_en4, next_pc_sel4;
    logic        alu_op1_sel4, alu_op2_sel4, jb_op1_sel4, illegal4;
    logic [3:0]  dm_w_en4;
    logic [3:0]  instret4;

    logic [14:0] got_vec, got_vec4;

    int n_cmp = 0;
    int n_bad = 0;
    int count = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .alu_out(alu_out),
        .im_ready(im_ready), .dm_ready(dm_ready), .im_req(im_req), .ir_w_en(ir_w_en),
        .dm_req(dm_req), .dm_w_en(dm_w_en), .wb_en(wb_en), .wb_sel(wb_sel),
        .pc_w_en(pc_w_en), .next_pc_sel(next_pc_sel), .alu_op1_sel(alu_op1_sel),
        .alu_op2_sel(alu_op2_sel), .jb_op1_sel(jb_op1_sel), .illegal(illegal),
        .instret(instret)
    );

    multicycle_controller #(.COUNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .alu_out(alu_out),
        .im_ready(im_ready), .dm_ready(dm_ready), .im_req(im_req4), .ir_w_en(ir_w_en4),
        .dm_req(dm_req4), .dm_w_en(dm_w_en4), .wb_en(wb_en4), .wb_sel(wb_sel4),
        .pc_w_en(pc_w_en4), .next_pc_sel(next_pc_sel4), .alu_op1_sel(alu_op1_sel4),
        .alu_op2_sel(alu_op2_sel4), .jb_op1_sel(jb_op1_sel4), .illegal(illegal4),
        .instret(instret4)
    );

    assign got_vec  = {im_req, ir_w_en, dm_req, dm_w_en, wb_en, wb_sel, pc_w_en,
                       next_pc_sel, alu_op1_sel, alu_op2_sel, jb_op1_sel, illegal};
    assign got_vec4 = {im_req4, ir_w_en4, dm_req4, dm_w_en4, wb_en4, wb_sel4, pc_w_en4,
                       next_pc_sel4, alu_op1_sel4, alu_op2_sel4, jb_op1_sel4, illegal4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected vector, same field order as got_vec. sels = {op1, op2, jb, wbsel}.
    function automatic logic [14:0] mk(input logic im, input logic ir, input logic dq,
                                       input logic [3:0] mask, input logic wbe,
                                       input logic pcw, input logic nps, input logic ill,
                                       input logic [3:0] sels);
        return {im, ir, dq, mask, wbe, sels[0], pcw, nps, sels[3], sels[2], sels[1], ill};
    endfunction

    function automatic logic [3:0] sel_bits(input logic [4:0] op);
        logic op1, op2, jb, wbs;
        op1 = (op == AUIPC) || (op == JAL) || (op == JALR);
        op2 = !((op == OP) || (op == BRANCH));
        jb  = (op != JALR);
        wbs = (op != LOAD);
        return {op1, op2, jb, wbs};
    endfunction

    function automatic logic legal_op(input logic [4:0] op);
        logic [4:0] tbl [9];
        tbl = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
        foreach (tbl[k]) if (tbl[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3);
        if (f3 == 3'b000) return 4'b0001;
        if (f3 == 3'b001) return 4'b0011;
        return 4'b1111;
    endfunction

    // One clock cycle: apply readies, compare at the falling edge, then
    // account for a retirement at the following rising edge.
    task automatic cyc(input logic imr, input logic dmr, input logic [14:0] exp);
        im_ready = imr;
        dm_ready = dmr;
        @(negedge clk);
        check_val("outs", {17'd0, got_vec}, {17'd0, exp});
        check_val("instret", instret, 32'(count));
        check_val("outs_w4", {17'd0, got_vec4}, {17'd0, exp});
        check_val("instret_w4", {28'd0, instret4}, 32'(count & 15));
        @(posedge clk);
        #1;
        if (exp[5]) count++;
    endtask

    task automatic boot_cycle();
        cyc(1'($urandom), 1'($urandom), 15'd0);
    endtask

    // Reference for one instruction. abort_mem drops rst_n in the second
    // MEM wait cycle and checks the asynchronous clear.
    task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input logic alu,
                             input int imw, input int dmw, input logic abort_mem);
        logic [3:0] s;
        logic [3:0] m;
        logic       is_mem;
        s = sel_bits(op);
        m = (op == STORE) ? exp_mask(f3) : 4'b0000;
        is_mem = (op == LOAD) || (op == STORE);
        opcode  = 5'($urandom);
        func3   = 3'($urandom);
        alu_out = 1'($urandom);
        for (int i = 0; i < imw; i++)
            cyc(1'b0, 1'($urandom), mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0));
        cyc(1'b1, 1'($urandom), mk(1, 1, 0, 4'd0, 0, 0, 0, 0, 4'd0));
        opcode = op; func3 = f3; alu_out = alu;
        cyc(1'($urandom), 1'($urandom), mk(0, 0, 0, 4'd0, 0, 0, 0, 0, s));
        if (op == BRANCH) begin
            cyc(1'($urandom), 1'($urandom), mk(0, 0, 0, 4'd0, 0, 1, ~alu, 0, s));
        end else if (!legal_op(op)) begin
            cyc(1'($urandom), 1'($urandom), mk(0, 0, 0, 4'd0, 0, 1, 1, 1, s));
        end else begin
            cyc(1'($urandom), 1'($urandom), mk(0, 0, 0, 4'd0, 0, 0, 0, 0, s));
            if (is_mem) begin
                for (int i = 0; i < dmw; i++) begin
                    if (abort_mem && i == 1) begin
                        im_ready = 1'b1; dm_ready = 1'b0;
                        @(negedge clk);
                        #2;
                        rst_n = 1'b0;
                        #1;
                        check_val("rst_outs", {17'd0, got_vec}, 32'd0);
                        check_val("rst_instret", instret, 32'd0);
                        check_val("rst_outs_w4", {17'd0, got_vec4}, 32'd0);
                        check_val("rst_instret_w4", {28'd0, instret4}, 32'd0);
                        count = 0;
                        @(posedge clk);
                        #1;
                        rst_n = 1'b1;
                        boot_cycle();
                        $display("instr op=%b f3=%b aborted by reset in MEM", op, f3);
                        return;
                    end
                    cyc(1'($urandom), 1'b0, mk(0, 0, 1, m, 0, 0, 0, 0, s));
                end
                if (op == STORE) begin
                    cyc(1'($urandom), 1'b1, mk(0, 0, 1, m, 0, 1, 1, 0, s));
                end else begin
                    cyc(1'($urandom), 1'b1, mk(0, 0, 1, m, 0, 0, 0, 0, s));
                end
            end
            if (op != STORE)
                cyc(1'($urandom), 1'($urandom),
                    mk(0, 0, 0, 4'd0, 1, 1, !((op == JAL) || (op == JALR)), 0, s));
        end
        $display("instr op=%b f3=%b alu=%b imw=%0d dmw=%0d instret=%0d",
                 op, f3, alu, imw, dmw, count);
    endtask

    initial begin
        logic [4:0] ops [9];
        logic [4:0] op;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
        rst_n = 1'b0; opcode = 5'd0; func3 = 3'd0; alu_out = 1'b0;
        im_ready = 1'b1; dm_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", {17'd0, got_vec}, 32'd0);
        check_val("reset_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        boot_cycle();

        // Directed cases.
        run_instr(OPIMM, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(LOAD,  3'b010, 1'b0, 1, 2, 1'b0);
        run_instr(STORE, 3'b001, 1'b0, 0, 1, 1'b0);
        run_instr(STORE, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(BRANCH, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(BRANCH, 3'b001, 1'b0, 2, 0, 1'b0);
        run_instr(5'b11111, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(JAL,  3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(JALR, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(LOAD, 3'b000, 1'b0, 0, 4, 1'b1);

        // Random mix, long enough to wrap the 4-bit counter several times.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) op = 5'($urandom);
            else                           op = ops[$urandom_range(0, 8)];
            run_instr(op, 3'($urandom), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
